// File: rtl/cpu_instr_fetch_pkg.sv
// cpu_instr_fetch_pkg: opcode width, fetch state encodings and opcode values shared by the fetch unit
package cpu_instr_fetch_pkg;
    localparam int OP_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [OP_W-1:0] OP_NOP = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB = 5'd2;
    localparam logic [OP_W-1:0] OP_AND = 5'd3;
    localparam logic [OP_W-1:0] OP_OR  = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR = 5'd5;
endpackage

// File: rtl/cpu_prog_mem.sv
// cpu_prog_mem: program store, synchronous write and combinational read
module cpu_prog_mem import cpu_instr_fetch_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int W = cpu_instr_fetch_pkg::OP_W,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cpu_instr_fetch.sv
// cpu_instr_fetch: program store, PC/IR and run/step/halt sequencing for the control FSM.
// Defining FETCH_BREAKPOINT_EN adds a PC breakpoint (bp_en_i, bp_addr_i, bp_hit_o).
module cpu_instr_fetch import cpu_instr_fetch_pkg::*; #(
    parameter int PROG_DEPTH = 16,
    parameter int OP_W = cpu_instr_fetch_pkg::OP_W,
    localparam int PC_W = $clog2(PROG_DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            prog_we_i,
    input  logic [PC_W-1:0] prog_addr_i,
    input  logic [OP_W-1:0] prog_data_i,
    input  logic [PC_W-1:0] prog_last_i,
    input  logic            run_i,
    input  logic            step_i,
    input  logic            clr_i,
    input  logic            pc_inc_i,
    output logic            exec_enable_o,
    output logic [OP_W-1:0] operation_o,
    output logic [PC_W-1:0] pc_o,
    output logic            busy_o,
    output logic            halted_o,
    output logic            error_o
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic            bp_en_i,
    input  logic [PC_W-1:0] bp_addr_i,
    output logic            bp_hit_o
`endif
);
    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [OP_W-1:0] ir_q, mem_rd;
    logic            err_q, step_q, step_flag_q, last_q;
    logic            step_rise, run_go, bp_take;

    assign step_rise     = step_i & ~step_q;
    assign exec_enable_o = state_q == S_PULSE;
    assign busy_o        = state_q == S_PULSE || state_q == S_GAP;
    assign halted_o      = state_q == S_HALT;
    assign error_o       = err_q;
    assign operation_o   = ir_q;
    assign pc_o          = pc_q;

    cpu_prog_mem #(.DEPTH(PROG_DEPTH), .W(OP_W)) u_mem (
        .clk_i   (clk_i),
        .we_i    (prog_we_i && (state_q == S_IDLE || state_q == S_HALT)),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .raddr_i (pc_q),
        .rdata_o (mem_rd)
    );

`ifdef FETCH_BREAKPOINT_EN
    logic run_q, bp_hold_q, skip_q, skip;
    // a run resumed after a hit steps over the breakpoint once; hold blocks run until it is re-raised
    assign skip    = skip_q | (run_i & ~run_q & bp_hit_o);
    assign run_go  = run_i & ~bp_hold_q;
    assign bp_take = run_go && bp_en_i && pc_q == bp_addr_i && !skip &&
                     (state_q == S_IDLE || (state_q == S_GAP && !last_q && !step_flag_q));

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            run_q     <= 1'b0;
            bp_hold_q <= 1'b0;
            skip_q    <= 1'b0;
            bp_hit_o  <= 1'b0;
        end else begin
            run_q <= run_i;
            if (clr_i) begin
                bp_hold_q <= 1'b0;
                skip_q    <= 1'b0;
                bp_hit_o  <= 1'b0;
            end else begin
                bp_hold_q <= bp_take | (bp_hold_q & run_i);
                skip_q    <= state_q != S_PULSE && skip;
                bp_hit_o  <= bp_take | (bp_hit_o & ~(run_i & ~run_q));
            end
        end
`else
    assign run_go  = run_i;
    assign bp_take = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            err_q       <= 1'b0;
            step_q      <= 1'b0;
            step_flag_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            step_q <= step_i;
            if (clr_i) begin
                state_q     <= S_IDLE;
                pc_q        <= '0;
                ir_q        <= '0;
                err_q       <= 1'b0;
                step_flag_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE:
                        if (run_go) state_q <= bp_take ? S_IDLE : S_PULSE;
                        else if (step_rise) begin
                            state_q     <= S_PULSE;
                            step_flag_q <= 1'b1;
                        end
                    S_PULSE:
                        if (pc_inc_i) begin
                            ir_q    <= mem_rd;
                            pc_q    <= pc_q + 1'b1;
                            last_q  <= pc_q == prog_last_i;
                            state_q <= S_GAP;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_HALT;
                        end
                    S_GAP:
                        if (last_q) state_q <= S_HALT;
                        else if (step_flag_q || !run_i) begin
                            state_q     <= S_IDLE;
                            step_flag_q <= 1'b0;
                        end else state_q <= bp_take ? S_IDLE : S_PULSE;
                    default: state_q <= S_HALT;
                endcase
            end
        end
endmodule

// File: tb/tb_cpu_instr_fetch.sv
// tb_cpu_instr_fetch: scoreboard bench for cpu_instr_fetch with a stub control FSM
module tb_cpu_instr_fetch;
    localparam int DEPTH = 16;
    localparam int PW = 4;
    localparam int OW = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          prog_we_i = 1'b0;
    logic [PW-1:0] prog_addr_i = '0;
    logic [OW-1:0] prog_data_i = '0;
    logic [PW-1:0] prog_last_i = '0;
    logic          run_i = 1'b0;
    logic          step_i = 1'b0;
    logic          clr_i = 1'b0;
    logic          pc_inc_i;
    logic          exec_enable_o;
    logic [OW-1:0] operation_o;
    logic [PW-1:0] pc_o;
    logic          busy_o, halted_o, error_o;
`ifdef FETCH_BREAKPOINT_EN
    logic          bp_en_i = 1'b0;
    logic [PW-1:0] bp_addr_i = '0;
    logic          bp_hit_o;
`endif

    logic          withhold = 1'b0;
    logic [OW-1:0] model_mem [DEPTH];
    int            sb [$];
    int            n_chk = 0, n_pass = 0, n_pulse = 0, cyc = 0, last_pulse = -1;
    bit            pend = 0, gap_chk = 0;

    // stub control FSM: answers every exec_enable pulse unless told to withhold
    assign pc_inc_i = exec_enable_o & ~withhold;

    always #5 clk_i = ~clk_i;

    cpu_instr_fetch #(.PROG_DEPTH(DEPTH), .OP_W(OW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_data_i   (prog_data_i),
        .prog_last_i   (prog_last_i),
        .run_i         (run_i),
        .step_i        (step_i),
        .clr_i         (clr_i),
        .pc_inc_i      (pc_inc_i),
        .exec_enable_o (exec_enable_o),
        .operation_o   (operation_o),
        .pc_o          (pc_o),
        .busy_o        (busy_o),
        .halted_o      (halted_o),
        .error_o       (error_o)
`ifdef FETCH_BREAKPOINT_EN
        ,
        .bp_en_i       (bp_en_i),
        .bp_addr_i     (bp_addr_i),
        .bp_hit_o      (bp_hit_o)
`endif
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        prog_we_i = 1'b1;
        prog_addr_i = PW'(a);
        prog_data_i = OW'(d);
        tick(1);
        prog_we_i = 1'b0;
        model_mem[a] = OW'(d);
    endtask

    task automatic clr();
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int max);
        int n = 0;
        while (!halted_o && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, int'(halted_o), 1);
    endtask

    // monitor: an instruction is consumed in the cycle exec_enable and pc_inc meet; IR is compared one cycle later
    always @(negedge clk_i) begin
        cyc++;
        if (pend) begin
            pend = 0;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("operation", int'(operation_o), sb.pop_front());
        end
        if (exec_enable_o) begin
            n_pulse++;
            if (gap_chk && last_pulse >= 0) chk("pulse_spacing", cyc - last_pulse, 2);
            last_pulse = cyc;
            if (pc_inc_i) pend = 1;
        end
    end

    initial begin
        int p0;
        tick(2);
        chk("rst_exec", int'(exec_enable_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_halt", int'(halted_o), 0);
        chk("rst_err", int'(error_o), 0);
        chk("rst_pc", int'(pc_o), 0);
        chk("rst_op", int'(operation_o), 0);
        rst_ni = 1'b1;
        tick(1);
        for (int i = 0; i < DEPTH; i++) wr(i, i < 4 ? i + 1 : (i * 7 + 3) % 32);

        // free run over mem[0..3]
        prog_last_i = 4'd3;
        for (int i = 0; i < 4; i++) sb.push_back(int'(model_mem[i]));
        p0 = n_pulse;
        gap_chk = 1;
        last_pulse = -1;
        run_i = 1'b1;
        tick(1);
        chk("run_latency", int'(exec_enable_o), 1);
        wait_halt("run_halt", 30);
        run_i = 1'b0;
        gap_chk = 0;
        chk("run_pc", int'(pc_o), 4);
        chk("run_pulses", n_pulse - p0, 4);
        tick(2);
        chk("halt_ignores_run_gone", int'(halted_o), 1);

        // single step
        clr();
        chk("clr_from_halt", int'(halted_o), 0);
        sb.push_back(int'(model_mem[0]));
        sb.push_back(int'(model_mem[1]));
        p0 = n_pulse;
        for (int k = 0; k < 2; k++) begin
            step_i = 1'b1;
            tick(1);
            step_i = 1'b0;
            tick(4);
        end
        chk("step_pulses", n_pulse - p0, 2);
        chk("step_pc", int'(pc_o), 2);
        chk("step_idle", int'(busy_o | halted_o), 0);
        sb.push_back(int'(model_mem[2]));
        step_i = 1'b1;
        tick(10);
        step_i = 1'b0;
        tick(2);
        chk("step_held_pulses", n_pulse - p0, 3);
        chk("step_held_pc", int'(pc_o), 3);

        // run dropped in the GAP after the first instruction
        clr();
        sb.push_back(int'(model_mem[0]));
        run_i = 1'b1;
        tick(2);
        chk("pause_in_gap", int'(busy_o & ~exec_enable_o), 1);
        run_i = 1'b0;
        tick(3);
        chk("pause_idle", int'(busy_o | halted_o), 0);
        chk("pause_pc", int'(pc_o), 1);
        for (int i = 1; i < 4; i++) sb.push_back(int'(model_mem[i]));
        run_i = 1'b1;
        wait_halt("resume_halt", 20);
        run_i = 1'b0;
        chk("resume_pc", int'(pc_o), 4);

        // missing handshake
        clr();
        withhold = 1'b1;
        run_i = 1'b1;
        tick(1);
        chk("hs_pulse", int'(exec_enable_o), 1);
        tick(1);
        run_i = 1'b0;
        withhold = 1'b0;
        chk("hs_error", int'(error_o), 1);
        chk("hs_halt", int'(halted_o), 1);
        chk("hs_pc", int'(pc_o), 0);
        clr();
        chk("hs_clr_err", int'(error_o), 0);
        chk("hs_clr_halt", int'(halted_o), 0);
        chk("hs_clr_pc", int'(pc_o), 0);

`ifdef FETCH_BREAKPOINT_EN
        // breakpoint at address 2, then resume by toggling run
        bp_en_i = 1'b1;
        bp_addr_i = 4'd2;
        sb.push_back(int'(model_mem[0]));
        sb.push_back(int'(model_mem[1]));
        p0 = n_pulse;
        run_i = 1'b1;
        tick(10);
        chk("bp_pulses", n_pulse - p0, 2);
        chk("bp_idle", int'(busy_o | halted_o), 0);
        chk("bp_pc", int'(pc_o), 2);
        chk("bp_hit", int'(bp_hit_o), 1);
        run_i = 1'b0;
        tick(1);
        sb.push_back(int'(model_mem[2]));
        sb.push_back(int'(model_mem[3]));
        run_i = 1'b1;
        tick(1);
        chk("bp_hit_cleared", int'(bp_hit_o), 0);
        wait_halt("bp_resume_halt", 20);
        run_i = 1'b0;
        bp_en_i = 1'b0;
        chk("bp_resume_pc", int'(pc_o), 4);
        clr();
`endif

        // wrap past PROG_DEPTH-1 and a write attempted while busy
        prog_last_i = 4'd15;
        for (int i = 0; i < DEPTH; i++) sb.push_back(int'(model_mem[i]));
        run_i = 1'b1;
        tick(3);
        chk("busy_during_write", int'(busy_o), 1);
        prog_we_i = 1'b1;
        prog_addr_i = 4'd15;
        prog_data_i = ~model_mem[15];
        tick(1);
        prog_we_i = 1'b0;
        wait_halt("wrap_halt", 60);
        run_i = 1'b0;
        chk("wrap_pc", int'(pc_o), 0);
        chk("wrap_err", int'(error_o), 0);

        // write accepted while halted
        wr(0, 9);
        clr();
        prog_last_i = 4'd0;
        sb.push_back(9);
        run_i = 1'b1;
        wait_halt("halt_write_halt", 10);
        run_i = 1'b0;
        chk("halt_write_pc", int'(pc_o), 1);

        // reset mid-instruction drops exec_enable without a clock edge
        clr();
        prog_last_i = 4'd3;
        run_i = 1'b1;
        tick(1);
        chk("pre_rst_exec", int'(exec_enable_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_exec", int'(exec_enable_o), 0);
        chk("async_rst_busy", int'(busy_o), 0);
        run_i = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        tick(2);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_instr_fetch.md
# cpu_instr_fetch

Instruction-fetch and sequencing unit on the upstream side of the CPU control FSM. Holds a loadable program store, PC and instruction register. Generates the `exec_enable` edges that start each fetch, and answers the FSM's `pc_inc` with the next opcode. Provides run, single-step and halt control towards the host/testbench.

## Interface
- `PROG_DEPTH`, 16: program store entries; power of two, ≥2.
- `OP_W`, 5: opcode width; must match the ALU opcode width.
- `PC_W`, `$clog2(PROG_DEPTH)`: derived, not overridden.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `prog_we_i` in 1: program store write strobe; honoured only in IDLE or HALT.
- `prog_addr_i` in PC_W: program store write address.
- `prog_data_i` in OP_W: opcode to write.
- `prog_last_i` in PC_W: address of the last instruction in the program.
- `run_i` in 1: level; while high, instructions issue back-to-back.
- `step_i` in 1: rising edge in IDLE issues exactly one instruction.
- `clr_i` in 1: synchronous pulse; PC←0, IR←0, error cleared, state←IDLE; wins over everything.
- `pc_inc_i` in 1: from control FSM; consume current PC.
- `exec_enable_o` out 1: to control FSM; one-cycle high pulse per instruction.
- `operation_o` out OP_W: instruction register, to FSM `operation_i`.
- `pc_o` out PC_W: current PC.
- `busy_o` out 1: high in PULSE or GAP.
- `halted_o` out 1: high in HALT.
- `error_o` out 1: sticky; set when a PULSE cycle sees no `pc_inc_i`.

## Operation
- States: IDLE, PULSE, GAP, HALT.
- IDLE:
  - `run_i`=1 → PULSE.
  - Otherwise, a `step_i` rising edge → PULSE with step flag set.
  - Program writes are accepted.
- PULSE: `exec_enable_o`=1.
  - `pc_inc_i`=1 is required in the same cycle. On that clock edge: IR←mem[PC]; PC←PC+1 modulo PROG_DEPTH → GAP.
  - If `pc_inc_i`=0: set `error_o`; PC and IR are unchanged → HALT.
- GAP: `exec_enable_o`=0; the FSM executes IR this cycle. Exit checks, in priority order:
  - The issued instruction was at `prog_last_i` → HALT.
  - Step flag set, or `run_i`=0 → IDLE; clear the step flag.
  - Otherwise → PULSE.
- HALT: `run_i` and `step_i` are ignored; program writes are accepted; only `clr_i` leaves HALT.
- `run_i` falling mid-instruction: the current PULSE/GAP completes; the unit then idles with PC preserved. A later `run_i` resumes from that PC.
- `step_i` edge detection uses a registered copy of `step_i`. A step edge while busy is dropped.
- PC wrap: PROG_DEPTH−1 increments to 0. HALT is taken only via `prog_last_i`.
- Program write and `pc_inc_i` to the same address in one cycle cannot occur, because writes are ignored while busy.

## Timing
- Reset values:
  - state IDLE
  - PC 0, IR 0
  - `exec_enable_o` 0, `busy_o` 0, `halted_o` 0, `error_o` 0
  - step edge register 0
  - store contents undefined
- All outputs are registered or decoded from state only; none are combinational from inputs.
- Throughput: one instruction per 2 cycles (PULSE, GAP).
- Latency, `run_i` rising → first `exec_enable_o`: 1 cycle.
- `operation_o` is valid from the cycle after `pc_inc_i` and stays stable until the next `pc_inc_i`.
- Program store: synchronous write, combinational read.
- Reset mid-operation returns to IDLE immediately; `exec_enable_o` falls asynchronously.

## Configuration
- Macro `FETCH_BREAKPOINT_EN`. When defined, adds:
  - Inputs `bp_en_i` (1) and `bp_addr_i` (PC_W).
  - Output `bp_hit_o` (1): sticky; cleared by `clr_i` or by the next `run_i` rising edge.
- Breakpoint behaviour: in IDLE or GAP with `run_i`=1, if `bp_en_i`=1 and PC==`bp_addr_i`:
  - Go to IDLE instead of PULSE and set `bp_hit_o`.
  - `run_i` must fall and rise again to continue. The resumed run ignores the breakpoint for its first instruction.
  - `step_i` is never stopped by the breakpoint.
- Undefined: the ports are absent and no breakpoint check exists.

## Structure
- Shared package/header holds: OP_W, the fetch state encodings, and the existing opcode defines.
- Sub-module `cpu_prog_mem` (PROG_DEPTH×OP_W register array: sync write, async read). The sequencer, PC and IR live in `cpu_instr_fetch`.

## Test plan
- Run with stub FSM:
  - Load mem[0..3]=5'd1,5'd2,5'd3,5'd4; `prog_last_i`=3; raise `run_i`.
  - Expect `exec_enable_o` pulses 2 cycles apart and `operation_o` sequence 1,2,3,4.
  - Then `halted_o`=1 and PC=4.
- Single step: `prog_last_i`=3, `run_i`=0.
  - Two `step_i` edges → exactly two pulses; `operation_o`=1 then 2; PC=2; IDLE.
  - Step held high for 10 cycles → one pulse only.
- Run pause: drop `run_i` in the GAP after the first instruction.
  - Expect IDLE with PC=1.
  - Re-raise `run_i` → next opcode is 2.
- Missing handshake: stub withholds `pc_inc_i` in PULSE.
  - Expect `error_o`=1, HALT, PC unchanged.
  - `clr_i` → IDLE, PC=0, `error_o`=0.
- Wrap and write gating:
  - PROG_DEPTH=16, `prog_last_i`=15, start at PC 14 → PC wraps to 0 and the unit HALTs.
  - A `prog_we_i` asserted while busy leaves memory unchanged.
- `FETCH_BREAKPOINT_EN`: `bp_addr_i`=2, run.
  - Expect 2 instructions, then IDLE with `bp_hit_o`=1.
  - Toggle `run_i` → execution resumes at opcode 3.
